vga_tile_renderer: RTL and testbench
====================================

// Module: vga_tile_renderer
// PURPOSE
//  Parametrised tile-map frame renderer for the maze game, downstream of the VGA timing generator.
//  Per pixel: looks up the map tile, overlays up to NUM_SPRITES sprites with fixed priority,
//  transparency and optional blinking, and emits registered 4-bit RGB.
//  Map and sprite ROMs are external (1-cycle read latency).
//  Sprite positions are frame-synchronised to prevent tearing.
// PARAMETERS
//  TILE_LOG2     4           log2 of tile edge in pixels (tile = 16x16)
//  MAP_COLS      40          visible tiles per row; tile columns >= MAP_COLS render black
//  MAP_ROWS      30          visible tile rows; tile rows >= MAP_ROWS render black
//  NUM_SPRITES   3           sprite slots; index 0 has highest priority
//  BLINK_PERIOD  25_000_000  clk cycles per blink half-period
// PORTS
//  clk          in   1               pixel-domain clock
//  rst          in   1               reset, asynchronous, active-high
//  i_pix_valid  in   1               current i_col/i_row are in the active area
//  i_col        in   10              pixel column
//  i_row        in   10              pixel row
//  i_spr_en     in   NUM_SPRITES     per-slot enable
//  i_spr_blink  in   NUM_SPRITES     per-slot blink enable
//  i_spr_bcol   in   NUM_SPRITES*6   per-slot tile column, slot k at [6k+5:6k]
//  i_spr_brow   in   NUM_SPRITES*6   per-slot tile row, slot k at [6k+5:6k]
//  o_map_en     out  1               map ROM read enable (= i_pix_valid)
//  o_map_addr   out  11              {i_col[9:TILE_LOG2] (6 bits), i_row[8:TILE_LOG2] (5 bits)}
//  i_map_data   in   16              map pixel: R=[15:12], G=[11:8], B=[7:4]
//  o_spr_en     out  1               sprite ROM read enable (= i_pix_valid)
//  o_spr_addr   out  SIW+2*TILE_LOG2 {winning slot, i_row[TILE_LOG2-1:0], i_col[TILE_LOG2-1:0]}
//                                    SIW = max(1, $clog2(NUM_SPRITES))
//  i_spr_data   in   16              sprite pixel: R=[3:0], G=[7:4], B=[11:8], [15]=transparent
//  o_valid      out  1               o_red/o_green/o_blue correspond to an active pixel
//  o_red        out  4               red
//  o_green      out  4               green
//  o_blue       out  4               blue
//  o_blink_ph   out  1               current blink phase (1 = blinking sprites hidden)
// BEHAVIOUR
//  Reset: o_valid, o_red, o_green, o_blue, o_blink_ph = 0; shadow sprite regs = 0 (all disabled);
//    blink counter = 0; pipeline valids = 0.
//  Shadow latch: when i_pix_valid && i_col==0 && i_row==0, copy i_spr_en/blink/bcol/brow into
//    shadow regs. Only shadows are used for rendering. The frame-start pixel itself uses the new values.
//  S0 (comb, input cycle): bcol = i_col>>TILE_LOG2, brow = i_row>>TILE_LOG2.
//    Slot k hits when en_k && !(blink_k && phase) && bcol==bcol_k && brow==brow_k.
//    Winner = lowest hitting k, else 0. Drive ROM addresses/enables.
//    oob = bcol>=MAP_COLS || brow>=MAP_ROWS.
//  S1 (reg): valid, hit, oob. ROM data is available this cycle.
//  S2 (reg, outputs):
//    !valid -> rgb 0, o_valid 0.
//    oob -> 0.
//    hit && !i_spr_data[15] -> sprite RGB.
//    otherwise -> map RGB.
//  Latency: exactly 2 clk from input pixel to o_valid/rgb. Fully pipelined, one pixel per clk,
//    no stalls.
//  Blink: counter runs 0..BLINK_PERIOD-1. On reaching BLINK_PERIOD-1 it wraps to 0 and phase toggles.
//    Runs regardless of i_pix_valid.
//  Transparent sprite pixel falls through to the map, never to a lower-priority sprite.
//  Reset mid-frame: outputs go 0 immediately. Sprites stay invisible until the next frame-start latch.
// STRUCTURE
//  vga_pkg (shared): rgb_t struct {r,g,b} 4b each; unpack_map()/unpack_spr() functions;
//    SPR_TRANSP_BIT = 15.
//  Sub-module blink_timer #(PERIOD) (clk, rst, o_phase, o_tick); reused by HUD logic.
// TESTING
//  T1 rst held 5 clk, pixels driven -> o_valid=0, rgb=0, o_blink_ph=0;
//     release -> first o_valid exactly 2 clk after first i_pix_valid.
//  T2 slot0 at (3,2), pixel (50,40), i_spr_data=16'h0A5F -> rgb = R=F, G=5, B=A;
//     o_spr_addr = {0, 4'h8, 4'h2}.
//  T3 slots 0 and 1 both at (5,5), i_spr_data[15]=1, i_map_data=16'h1230 -> map rgb 1/2/3;
//     slot1 never selected.
//  T4 i_col=640 (tile 40) with valid=1 -> rgb 0;
//     i_pix_valid=0 -> o_valid 0 after 2 clk.
//  T5 move slot0 mid-frame -> old position rendered until (0,0) pixel, new position from that pixel on.
//  T6 BLINK_PERIOD=4, slot0 blink=1 -> phase toggles every 4 clk; sprite hidden while phase=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel path.
// Contents:
//   rgb_t           4-bit-per-channel colour
//   SPR_TRANSP_BIT  sprite ROM word bit that marks a transparent pixel
//   unpack_map()    map ROM word -> rgb_t   (R=[15:12], G=[11:8], B=[7:4])
//   unpack_spr()    sprite ROM word -> rgb_t (R=[3:0], G=[7:4], B=[11:8])
package vga_pkg;

  localparam int SPR_TRANSP_BIT = 15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t unpack_map(input logic [15:0] d);
    rgb_t p;
    p.r = d[15:12];
    p.g = d[11:8];
    p.b = d[7:4];
    return p;
  endfunction

  // Sprite art uses the opposite channel order to the map art.
  function automatic rgb_t unpack_spr(input logic [15:0] d);
    rgb_t p;
    p.r = d[3:0];
    p.g = d[7:4];
    p.b = d[11:8];
    return p;
  endfunction

endpackage

// File: rtl/vga_tile_renderer_blink_timer.sv
// Free-running blink timer, also used by the HUD logic.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   o_phase  out  blink phase, toggles once every PERIOD cycles
//   o_tick   out  high on the last cycle of each half-period
// The counter runs 0..PERIOD-1; the cycle it sits at PERIOD-1 it wraps
// and the phase flips on the same edge.
module blink_timer #(
  parameter int PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_phase,
  output logic o_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      o_phase <= 1'b0;
    end else if (o_tick) begin
      cnt     <= '0;
      o_phase <= ~o_phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map frame renderer: map tile lookup with up to NUM_SPRITES overlaid
// sprites (slot 0 wins), sprite transparency and blinking. Two-cycle
// pipeline, one pixel per clock; external ROMs have one cycle of latency.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_pix_valid, i_col, i_row      pixel from the timing generator
//   i_spr_en/blink/bcol/brow       sprite slot config, sampled at frame start
//   o_map_en, o_map_addr           map ROM request {tile col, tile row}
//   i_map_data                     map ROM word, one cycle after request
//   o_spr_en, o_spr_addr           sprite ROM request {slot, y in tile, x in tile}
//   i_spr_data                     sprite ROM word, one cycle after request
//   o_valid, o_red/green/blue      registered output pixel, 2 clk after input
//   o_blink_ph                     1 = blinking sprites hidden
module vga_tile_renderer
  import vga_pkg::*;
#(
  parameter int TILE_LOG2    = 4,
  parameter int MAP_COLS     = 40,
  parameter int MAP_ROWS     = 30,
  parameter int NUM_SPRITES  = 3,
  parameter int BLINK_PERIOD = 25_000_000,
  localparam int SIW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_pix_valid,
  input  logic [9:0]                   i_col,
  input  logic [9:0]                   i_row,
  input  logic [NUM_SPRITES-1:0]       i_spr_en,
  input  logic [NUM_SPRITES-1:0]       i_spr_blink,
  input  logic [NUM_SPRITES*6-1:0]     i_spr_bcol,
  input  logic [NUM_SPRITES*6-1:0]     i_spr_brow,
  output logic                         o_map_en,
  output logic [18-2*TILE_LOG2:0]      o_map_addr,
  input  logic [15:0]                  i_map_data,
  output logic                         o_spr_en,
  output logic [SIW+2*TILE_LOG2-1:0]   o_spr_addr,
  input  logic [15:0]                  i_spr_data,
  output logic                         o_valid,
  output logic [3:0]                   o_red,
  output logic [3:0]                   o_green,
  output logic [3:0]                   o_blue,
  output logic                         o_blink_ph
);

  // Blink phase
  logic blink_ph;

  blink_timer #(.PERIOD(BLINK_PERIOD)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .o_phase (blink_ph),
    .o_tick  ()
  );

  assign o_blink_ph = blink_ph;

  // Frame-synchronised sprite shadows. The frame-start pixel renders with the
  // freshly presented config, so the effective config bypasses the shadow then.
  logic                     frame_start;
  logic [NUM_SPRITES-1:0]   sh_en, sh_blink;
  logic [NUM_SPRITES*6-1:0] sh_bcol, sh_brow;
  logic [NUM_SPRITES-1:0]   eff_en, eff_blink;
  logic [NUM_SPRITES*6-1:0] eff_bcol, eff_brow;

  assign frame_start = i_pix_valid && (i_col == 10'd0) && (i_row == 10'd0);
  assign eff_en      = frame_start ? i_spr_en    : sh_en;
  assign eff_blink   = frame_start ? i_spr_blink : sh_blink;
  assign eff_bcol    = frame_start ? i_spr_bcol  : sh_bcol;
  assign eff_brow    = frame_start ? i_spr_brow  : sh_brow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en    <= '0;
      sh_blink <= '0;
      sh_bcol  <= '0;
      sh_brow  <= '0;
    end else if (frame_start) begin
      sh_en    <= i_spr_en;
      sh_blink <= i_spr_blink;
      sh_bcol  <= i_spr_bcol;
      sh_brow  <= i_spr_brow;
    end
  end

  // S0: tile coordinates, sprite hit search, ROM requests.
  // Tile coordinates are kept at full width so that tiles beyond the 6-bit
  // sprite range never alias onto a sprite position.
  logic [9:0]     bcol, brow;
  logic           hit0, oob0;
  logic [SIW-1:0] win0;

  assign bcol = i_col >> TILE_LOG2;
  assign brow = i_row >> TILE_LOG2;
  assign oob0 = (bcol >= 10'(MAP_COLS)) || (brow >= 10'(MAP_ROWS));

  // Scan from the lowest priority upwards so the last assignment is the winner.
  always_comb begin
    hit0 = 1'b0;
    win0 = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (eff_en[k] && !(eff_blink[k] && blink_ph) &&
          (bcol == 10'(eff_bcol[6*k +: 6])) &&
          (brow == 10'(eff_brow[6*k +: 6]))) begin
        hit0 = 1'b1;
        win0 = SIW'(k);
      end
    end
  end

  assign o_map_en   = i_pix_valid;
  assign o_map_addr = {i_col[9:TILE_LOG2], i_row[8:TILE_LOG2]};
  assign o_spr_en   = i_pix_valid;
  assign o_spr_addr = {win0, i_row[TILE_LOG2-1:0], i_col[TILE_LOG2-1:0]};

  // S1: pixel attributes line up with the ROM data arriving this cycle.
  logic valid1, hit1, oob1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1 <= 1'b0;
      hit1   <= 1'b0;
      oob1   <= 1'b0;
    end else begin
      valid1 <= i_pix_valid;
      hit1   <= hit0;
      oob1   <= oob0;
    end
  end

  // S2: colour select. A transparent sprite pixel shows the map, never a
  // lower-priority sprite, since only the winning slot was fetched.
  rgb_t px;

  always_comb begin
    px = '0;
    if (valid1 && !oob1) begin
      if (hit1 && !i_spr_data[SPR_TRANSP_BIT])
        px = unpack_spr(i_spr_data);
      else
        px = unpack_map(i_map_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_valid <= valid1;
      o_red   <= px.r;
      o_green <= px.g;
      o_blue  <= px.b;
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer. ROMs are emulated with a
// one-cycle read latency; expected pixels come from a tile/sprite model
// and are compared two clocks after each pixel is driven.
module tb_vga_tile_renderer;

  localparam int NS = 3;
  localparam int BP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_valid = 1'b0;
  logic [9:0]    col = '0, row = '0;
  logic [NS-1:0] spr_en = '0, spr_blink = '0;
  logic [NS*6-1:0] spr_bcol = '0, spr_brow = '0;
  logic          map_en, spr_rd_en;
  logic [10:0]   map_addr;
  logic [9:0]    spr_addr;
  logic [15:0]   map_data = '0, spr_data = '0;
  logic          o_valid, blink_ph;
  logic [3:0]    red, green, blue;

  vga_tile_renderer #(
    .TILE_LOG2(4), .MAP_COLS(40), .MAP_ROWS(30),
    .NUM_SPRITES(NS), .BLINK_PERIOD(BP)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pix_valid(pix_valid), .i_col(col), .i_row(row),
    .i_spr_en(spr_en), .i_spr_blink(spr_blink),
    .i_spr_bcol(spr_bcol), .i_spr_brow(spr_brow),
    .o_map_en(map_en), .o_map_addr(map_addr), .i_map_data(map_data),
    .o_spr_en(spr_rd_en), .o_spr_addr(spr_addr), .i_spr_data(spr_data),
    .o_valid(o_valid), .o_red(red), .o_green(green), .o_blue(blue),
    .o_blink_ph(blink_ph)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Clock edges since reset release; the blink phase is a pure function of it.
  int edges = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // ROM emulation state
  logic        map_ovr_on = 1'b0, spr_ovr_on = 1'b0;
  logic [15:0] map_ovr = '0, spr_ovr = '0;
  logic        rom_map_en = 1'b0, rom_spr_en = 1'b0;
  logic [10:0] rom_map_a = '0;
  logic [9:0]  rom_spr_a = '0;

  function automatic logic [15:0] map_fn(input logic [10:0] a);
    logic [31:0] h;
    if (map_ovr_on) return map_ovr;
    h = (32'(a) + 32'd7) * 32'h85EB_CA6B;
    return h[27:12];
  endfunction

  function automatic logic [15:0] spr_fn(input logic [9:0] a);
    logic [31:0] h;
    if (spr_ovr_on) return spr_ovr;
    h = (32'(a) + 32'd3) * 32'h9E37_79B1;
    return h[31:16];
  endfunction

  // Model: sprite config in force for the current frame
  logic [NS-1:0] m_en = '0, m_blink = '0;
  int m_bc[NS];
  int m_br[NS];

  logic [12:0] expq[$];

  function automatic logic model_phase();
    return ((edges / BP) % 2) == 1;
  endfunction

  task automatic model_clear();
    m_en = '0;
    m_blink = '0;
    for (int k = 0; k < NS; k++) begin m_bc[k] = 0; m_br[k] = 0; end
  endtask

  // Expected {valid, r, g, b} for a pixel sampled at the next clock edge.
  task automatic model_pixel(input logic v, input int c, input int r, output logic [12:0] e);
    int tc, tr, w;
    logic ph;
    logic [15:0] sd, md;
    logic [10:0] ma;
    logic [9:0]  sa;
    if (v && c == 0 && r == 0) begin
      m_en = spr_en;
      m_blink = spr_blink;
      for (int k = 0; k < NS; k++) begin
        m_bc[k] = int'(spr_bcol[6*k +: 6]);
        m_br[k] = int'(spr_brow[6*k +: 6]);
      end
    end
    e = '0;
    if (!v) return;
    tc = c / 16;
    tr = r / 16;
    if (tc >= 40 || tr >= 30) begin
      e = 13'h1000;
      return;
    end
    ph = model_phase();
    w = -1;
    for (int k = 0; k < NS; k++)
      if (w < 0 && m_en[k] && !(m_blink[k] && ph) && tc == m_bc[k] && tr == m_br[k])
        w = k;
    ma = {6'(tc), 5'(tr)};
    sa = {2'((w < 0) ? 0 : w), 4'(r % 16), 4'(c % 16)};
    md = map_fn(ma);
    sd = spr_fn(sa);
    if (w >= 0 && !sd[15]) e = {1'b1, sd[3:0], sd[7:4], sd[11:8]};
    else                   e = {1'b1, md[15:12], md[11:8], md[7:4]};
  endtask

  // One pixel per call: serve ROM reads, check the pixel from 2 clk ago, drive.
  task automatic step(input logic v, input int c, input int r);
    logic [12:0] e, ne;
    @(negedge clk);
    if (rom_map_en) map_data = map_fn(rom_map_a);
    if (rom_spr_en) spr_data = spr_fn(rom_spr_a);
    e = (expq.size() >= 2) ? expq.pop_front() : 13'h0;
    total++;
    if ({o_valid, red, green, blue} !== e) begin
      bad++;
      $display("FAIL pixel_out t=%0t: got v=%b rgb=%h/%h/%h want v=%b rgb=%h/%h/%h",
               $time, o_valid, red, green, blue, e[12], e[11:8], e[7:4], e[3:0]);
    end
    total++;
    if (blink_ph !== model_phase()) begin
      bad++;
      $display("FAIL blink_phase t=%0t: got %b want %b", $time, blink_ph, model_phase());
    end
    pix_valid = v;
    col = 10'(c);
    row = 10'(r);
    model_pixel(v, c, r, ne);
    expq.push_back(ne);
    #1;
    rom_map_en = map_en;
    rom_map_a  = map_addr;
    rom_spr_en = spr_rd_en;
    rom_spr_a  = spr_addr;
  endtask

  task automatic flush();
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
  endtask

  task automatic set_slot(input int k, input logic en, input logic bl, input int bc, input int br);
    spr_en[k] = en;
    spr_blink[k] = bl;
    spr_bcol[6*k +: 6] = 6'(bc);
    spr_brow[6*k +: 6] = 6'(br);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b0;
    expq.delete();
    model_clear();
    rom_map_en = 1'b0;
    rom_spr_en = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    model_clear();
    rom_map_en = 1'b0;
    rom_spr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      col = 10'(i * 17);
      row = 10'(i * 9);
      #1;
      total++;
      if ({o_valid, red, green, blue, blink_ph} !== 14'h0) begin
        bad++;
        $display("FAIL reset_hold: got v=%b rgb=%h/%h/%h ph=%b want all 0",
                 o_valid, red, green, blue, blink_ph);
      end
    end
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // The step checks cover the 2-clk latency: nothing valid until then.
    for (int i = 0; i < 6; i++) step(1'b1, 32 + i, 20);
    flush();
  endtask

  task automatic test_sprite_basic();
    spr_ovr_on = 1'b1;
    spr_ovr = 16'h0A5F;
    map_ovr_on = 1'b1;
    map_ovr = 16'h7770;
    set_slot(0, 1'b1, 1'b0, 3, 2);
    step(1'b1, 0, 0);
    step(1'b1, 50, 40);
    total++;
    if (spr_addr !== {2'd0, 4'h8, 4'h2}) begin
      bad++;
      $display("FAIL spr_addr_basic: got %h want %h", spr_addr, {2'd0, 4'h8, 4'h2});
    end
    total++;
    if (map_addr !== {6'd3, 5'd2}) begin
      bad++;
      $display("FAIL map_addr_basic: got %h want %h", map_addr, {6'd3, 5'd2});
    end
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    total++;
    if ({o_valid, red, green, blue} !== 13'h1F5A) begin
      bad++;
      $display("FAIL sprite_rgb_basic: got v=%b rgb=%h/%h/%h want 1 F/5/A",
               o_valid, red, green, blue);
    end
    flush();
    spr_ovr_on = 1'b0;
    map_ovr_on = 1'b0;
  endtask

  task automatic test_priority_transparent();
    spr_ovr_on = 1'b1;
    spr_ovr = 16'h8ABC;
    map_ovr_on = 1'b1;
    map_ovr = 16'h1230;
    set_slot(0, 1'b1, 1'b0, 5, 5);
    set_slot(1, 1'b1, 1'b0, 5, 5);
    set_slot(2, 1'b0, 1'b0, 0, 0);
    step(1'b1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 80 + $urandom_range(0, 15), 80 + $urandom_range(0, 15));
      total++;
      if (spr_addr[9:8] !== 2'd0) begin
        bad++;
        $display("FAIL priority_slot: got slot %0d want 0", spr_addr[9:8]);
      end
    end
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    total++;
    if ({o_valid, red, green, blue} !== 13'h1123) begin
      bad++;
      $display("FAIL transparent_map: got v=%b rgb=%h/%h/%h want 1 1/2/3",
               o_valid, red, green, blue);
    end
    flush();
    spr_ovr_on = 1'b0;
    map_ovr_on = 1'b0;
  endtask

  task automatic test_oob();
    map_ovr_on = 1'b1;
    map_ovr = 16'hFFF0;
    step(1'b1, 640, 16);
    step(1'b1, 639, 16);
    step(1'b1, 16, 480);
    step(1'b1, 1023, 1023);
    step(1'b0, 100, 100);
    step(1'b1, 100, 479);
    flush();
    map_ovr_on = 1'b0;
  endtask

  task automatic test_shadow();
    spr_ovr_on = 1'b1;
    spr_ovr = 16'h0CCC;
    map_ovr_on = 1'b1;
    map_ovr = 16'h1110;
    set_slot(0, 1'b1, 1'b0, 2, 2);
    set_slot(1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 0, 0);
    step(1'b1, 40, 40);
    step(1'b1, 100, 40);
    set_slot(0, 1'b1, 1'b0, 6, 2);
    step(1'b1, 40, 40);
    step(1'b1, 100, 40);
    step(1'b1, 0, 0);
    step(1'b1, 40, 40);
    step(1'b1, 100, 40);
    flush();
    spr_ovr_on = 1'b0;
    map_ovr_on = 1'b0;
  endtask

  task automatic test_blink();
    spr_ovr_on = 1'b1;
    spr_ovr = 16'h0DEF;
    map_ovr_on = 1'b1;
    map_ovr = 16'h2220;
    set_slot(0, 1'b1, 1'b1, 1, 1);
    step(1'b1, 0, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 20, 20);
    flush();
    set_slot(0, 1'b0, 1'b0, 0, 0);
    spr_ovr_on = 1'b0;
    map_ovr_on = 1'b0;
  endtask

  task automatic test_reset_midframe();
    map_ovr_on = 1'b1;
    map_ovr = 16'hFFF0;
    spr_ovr_on = 1'b1;
    spr_ovr = 16'h0123;
    set_slot(0, 1'b1, 1'b0, 4, 4);
    step(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 70, 70);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({o_valid, red, green, blue, blink_ph} !== 14'h0) begin
      bad++;
      $display("FAIL reset_async: got v=%b rgb=%h/%h/%h ph=%b want all 0",
               o_valid, red, green, blue, blink_ph);
    end
    pix_valid = 1'b0;
    expq.delete();
    model_clear();
    rom_map_en = 1'b0;
    rom_spr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 70, 70);
    step(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 70, 70);
    flush();
    map_ovr_on = 1'b0;
    spr_ovr_on = 1'b0;
  endtask

  task automatic randomize_slots();
    for (int k = 0; k < NS; k++)
      set_slot(k, 1'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
  endtask

  task automatic test_random();
    int c, r;
    for (int f = 0; f < 8; f++) begin
      randomize_slots();
      step(1'b1, 0, 0);
      for (int i = 0; i < 60; i++) begin
        if (i == 30) randomize_slots();
        c = ($urandom_range(0, 7) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 95);
        r = ($urandom_range(0, 7) == 0) ? $urandom_range(460, 1023) : $urandom_range(0, 95);
        step(1'($urandom_range(0, 4) != 0), c, r);
      end
    end
    flush();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sprite_basic();
    test_priority_transparent();
    test_oob();
    test_shadow();
    test_blink();
    test_reset_midframe();
    apply_reset(2);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
